// File: rtl/lc3b_pipe_chain.sv
// Pipeline register chain for the LC-3b datapath. Each stage holds a valid bit
// and a payload, with per-stage stall, younger-stage flush and valid/ready at both ends.
module lc3b_pipe_chain #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic [CNT_W-1:0]          retire_count,
    output logic [CNT_W-1:0]          bubble_count
);

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]             retire_q, retire_d;
    logic [CNT_W-1:0]             bubble_q, bubble_d;

    logic [STAGES:0]   acc;   // acc[i]: stage i can take a new entry this cycle
    logic [STAGES-1:0] go;    // go[i]: entry in stage i moves on this cycle
    logic [STAGES-1:0] kill;  // kill[i]: stage i is at or below the highest flush bit
    logic [STAGES-1:0] load;  // load[i]: stage i captures a surviving entry

    // The ready chain is walked from the oldest stage down, so one stage can
    // be refilled in the same cycle its entry leaves.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc          = '0;
        go           = '0;
        kill         = '0;
        acc[STAGES]  = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            go[i]  = valid_q[i] & ~stall[i] & acc[i+1];
            acc[i] = ~valid_q[i] | go[i];
        end
        kill[STAGES-1] = flush[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            kill[i] = flush[i] | kill[i+1];
        end
    end

    assign in_ready  = acc[0];
    assign out_valid = valid_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    // A killed source stage hands its successor a bubble, never its payload.
    always_comb begin
        load    = '0;
        valid_d = valid_q;
        data_d  = data_q;
        load[0] = in_valid & acc[0] & ~kill[0];
        for (int i = 1; i < STAGES; i++) begin
            load[i] = go[i-1] & ~kill[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            if (kill[i]) begin
                valid_d[i] = 1'b0;
            end else if (load[i]) begin
                valid_d[i] = 1'b1;
            end else if (go[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (load[0]) begin
            data_d[0] = in_data;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_comb begin
        retire_d = retire_q;
        bubble_d = bubble_q;
        if (out_valid && out_ready && (retire_q != {CNT_W{1'b1}})) begin
            retire_d = retire_q + 1'b1;
        end
        if (out_ready && !out_valid && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments; payloads are reset too because
    // debug tooling reads stage_data and expects zeros after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            data_q   <= '0;
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    assign stage_valid  = valid_q;
    assign stage_data   = data_q;
    assign retire_count = retire_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_lc3b_pipe_chain.sv
// Directed bench for lc3b_pipe_chain: table-driven cycle vectors for streaming,
// back-pressure, stall and flush, plus hand-written reset and saturation sequences.
module tb_lc3b_pipe_chain;

    localparam int W = 16;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic [S-1:0]  stall = '0;
    logic [S-1:0]  flush = '0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [S-1:0]  stage_valid;
    logic [S*W-1:0] stage_data;
    logic [15:0]   retire_count;
    logic [15:0]   bubble_count;

    logic          sat_in_ready, sat_out_valid;
    logic [W-1:0]  sat_out_data;
    logic [S-1:0]  sat_stage_valid;
    logic [S*W-1:0] sat_stage_data;
    logic [3:0]    sat_retire, sat_bubble;

    always #5 clk = ~clk;

    lc3b_pipe_chain #(.WIDTH(W), .STAGES(S), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall(stall), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .stage_valid(stage_valid),
        .stage_data(stage_data), .retire_count(retire_count), .bubble_count(bubble_count)
    );

    // Idle instance with narrow counters, used only to watch saturation.
    lc3b_pipe_chain #(.WIDTH(W), .STAGES(S), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(1'b0), .in_data(16'h0),
        .in_ready(sat_in_ready), .stall(4'b0000), .flush(4'b0000), .out_valid(sat_out_valid),
        .out_data(sat_out_data), .out_ready(1'b1), .stage_valid(sat_stage_valid),
        .stage_data(sat_stage_data), .retire_count(sat_retire), .bubble_count(sat_bubble)
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic [S-1:0] st;
        logic [S-1:0] fl;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [S-1:0] e_sv;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [W-1:0] d, input logic [S-1:0] st,
                       input logic [S-1:0] fl, input logic ordy, input logic e_ir,
                       input logic e_ov, input logic [W-1:0] e_od, input logic [S-1:0] e_sv);
        vecs[nvec] = '{iv, d, st, fl, ordy, e_ir, e_ov, e_od, e_sv};
        nvec++;
    endtask

    // Rows are applied just after a rising edge and checked at the falling edge.
    task automatic run_vecs(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            in_valid  = vecs[k].iv;
            in_data   = vecs[k].d;
            stall     = vecs[k].st;
            flush     = vecs[k].fl;
            out_ready = vecs[k].ordy;
            @(negedge clk);
            check("in_ready", k, 64'(in_ready), 64'(vecs[k].e_ir));
            check("out_valid", k, 64'(out_valid), 64'(vecs[k].e_ov));
            check("stage_valid", k, 64'(stage_valid), 64'(vecs[k].e_sv));
            if (vecs[k].e_ov) check("out_data", k, 64'(out_data), 64'(vecs[k].e_od));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b0;
        #1;
        check("rst_stage_valid", 0, 64'(stage_valid), 64'h0);
        check("rst_stage_data", 0, stage_data, 64'h0);
        check("rst_in_ready", 0, 64'(in_ready), 64'h1);
        check("rst_out_valid", 0, 64'(out_valid), 64'h0);
        check("rst_retire", 0, 64'(retire_count), 64'h0);
        check("rst_bubble", 0, 64'(bubble_count), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int g_stream, g_bp, g_stall, g_flush, g_lflush, g_end;

    initial begin
        logic [S-1:0] sv;
        int           src;

        // Streaming: 10 back-to-back pushes, out_ready high throughout.
        g_stream = nvec;
        for (int j = 0; j < 14; j++) begin
            sv = '0;
            for (int i = 0; i < S; i++) begin
                src = j - 1 - i;
                sv[i] = (src >= 0) && (src <= 9);
            end
            add(j < 10, W'(16'h1000 + j), 4'b0000, 4'b0000, 1'b1, 1'b1,
                j >= 4, W'(16'h1000 + j - 4), sv);
        end

        // Back-pressure: out_ready low until the chain is full, then released.
        g_bp = nvec;
        add(1, 16'h1000, 0, 0, 0, 1, 0, 16'h0000, 4'b0000);
        add(1, 16'h1001, 0, 0, 0, 1, 0, 16'h0000, 4'b0001);
        add(1, 16'h1002, 0, 0, 0, 1, 0, 16'h0000, 4'b0011);
        add(1, 16'h1003, 0, 0, 0, 1, 0, 16'h0000, 4'b0111);
        add(1, 16'h1004, 0, 0, 0, 0, 1, 16'h1000, 4'b1111);
        add(1, 16'h1004, 0, 0, 0, 0, 1, 16'h1000, 4'b1111);
        add(1, 16'h1004, 0, 0, 1, 1, 1, 16'h1000, 4'b1111);
        add(1, 16'h1005, 0, 0, 1, 1, 1, 16'h1001, 4'b1111);
        add(0, 16'h0000, 0, 0, 1, 1, 1, 16'h1002, 4'b1111);
        add(0, 16'h0000, 0, 0, 1, 1, 1, 16'h1003, 4'b1110);
        add(0, 16'h0000, 0, 0, 1, 1, 1, 16'h1004, 4'b1100);
        add(0, 16'h0000, 0, 0, 1, 1, 1, 16'h1005, 4'b1000);
        add(0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 4'b0000);

        // Stall of stage 2 for three cycles while streaming.
        g_stall = nvec;
        add(1, 16'h2000, 4'b0000, 0, 1, 1, 0, 16'h0000, 4'b0000);
        add(1, 16'h2001, 4'b0000, 0, 1, 1, 0, 16'h0000, 4'b0001);
        add(1, 16'h2002, 4'b0000, 0, 1, 1, 0, 16'h0000, 4'b0011);
        add(1, 16'h2003, 4'b0000, 0, 1, 1, 0, 16'h0000, 4'b0111);
        add(1, 16'h2004, 4'b0100, 0, 1, 0, 1, 16'h2000, 4'b1111);
        add(1, 16'h2004, 4'b0100, 0, 1, 0, 0, 16'h0000, 4'b0111);
        add(1, 16'h2004, 4'b0100, 0, 1, 0, 0, 16'h0000, 4'b0111);
        add(1, 16'h2004, 4'b0000, 0, 1, 1, 0, 16'h0000, 4'b0111);
        add(0, 16'h0000, 4'b0000, 0, 1, 1, 1, 16'h2001, 4'b1111);
        add(0, 16'h0000, 4'b0000, 0, 1, 1, 1, 16'h2002, 4'b1110);
        add(0, 16'h0000, 4'b0000, 0, 1, 1, 1, 16'h2003, 4'b1100);
        add(0, 16'h0000, 4'b0000, 0, 1, 1, 1, 16'h2004, 4'b1000);
        add(0, 16'h0000, 4'b0000, 0, 1, 1, 0, 16'h0000, 4'b0000);

        // Flush of stages 0..1 with a concurrent input on a full chain.
        g_flush = nvec;
        add(1, 16'h3000, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0000);
        add(1, 16'h3001, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0001);
        add(1, 16'h3002, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0011);
        add(1, 16'h3003, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0111);
        add(1, 16'h3004, 0, 4'b0011, 1, 1, 1, 16'h3000, 4'b1111);
        add(0, 16'h0000, 0, 4'b0000, 1, 1, 1, 16'h3001, 4'b1000);
        add(0, 16'h0000, 0, 4'b0000, 1, 1, 0, 16'h0000, 4'b0000);

        // Last-stage flush: output suppressed, whole chain emptied.
        g_lflush = nvec;
        add(1, 16'h4000, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0000);
        add(1, 16'h4001, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0001);
        add(1, 16'h4002, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0011);
        add(1, 16'h4003, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0111);
        add(0, 16'h0000, 0, 4'b1000, 1, 1, 0, 16'h0000, 4'b1111);
        add(0, 16'h0000, 0, 4'b0000, 0, 1, 0, 16'h0000, 4'b0000);
        g_end = nvec;

        do_reset();
        run_vecs(g_stream, g_bp - 1);
        @(negedge clk);
        check("stream_retire", 0, 64'(retire_count), 64'd10);
        check("stream_bubble", 0, 64'(bubble_count), 64'd4);

        do_reset();
        run_vecs(g_bp, g_stall - 1);
        @(negedge clk);
        check("bp_retire", 0, 64'(retire_count), 64'd6);
        check("bp_bubble", 0, 64'(bubble_count), 64'd1);

        do_reset();
        run_vecs(g_stall, g_flush - 1);
        @(negedge clk);
        check("stall_retire", 0, 64'(retire_count), 64'd5);

        do_reset();
        run_vecs(g_flush, g_lflush - 1);
        @(negedge clk);
        check("flush_retire", 0, 64'(retire_count), 64'd2);

        do_reset();
        run_vecs(g_lflush, g_end - 1);
        @(negedge clk);
        check("lflush_retire", 0, 64'(retire_count), 64'd0);
        check("lflush_bubble", 0, 64'(bubble_count), 64'd1);

        // Mid-stream asynchronous reset.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = W'(16'h5000 + j);
            @(posedge clk);
            #1;
        end
        check("mid_stage_valid", 0, 64'(stage_valid), 64'h7);
        check("mid_bubble", 0, 64'(bubble_count), 64'd3);
        check("mid_stage0", 0, 64'(stage_data[0 +: W]), 64'h5002);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stage_valid", 0, 64'(stage_valid), 64'h0);
        check("mid_rst_stage_data", 0, stage_data, 64'h0);
        check("mid_rst_bubble", 0, 64'(bubble_count), 64'h0);
        check("mid_rst_out_valid", 0, 64'(out_valid), 64'h0);
        check("mid_rst_in_ready", 0, 64'(in_ready), 64'h1);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Saturation of a 4-bit bubble counter on the idle instance.
        do_reset();
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("sat_bubble_14", 0, 64'(sat_bubble), 64'd14);
        @(posedge clk);
        @(negedge clk);
        check("sat_bubble_15", 0, 64'(sat_bubble), 64'd15);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sat_bubble_hold", 0, 64'(sat_bubble), 64'd15);
        check("sat_retire", 0, 64'(sat_retire), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
